// File: rtl/spi_2ph_lat_rx.sv
// spi_2ph_lat_rx: receive endpoint for the two-phase SPI output bus.
// SCLK1, SCLK2, LAT and SPI_SI are oversampled in the CLK domain. The block
// rebuilds the master/slave shift of the analog configuration register and
// moves the shifted word into DOUT on a LAT rise.
// Optional feature macro: SPI_RX_PARITY_CHK_EN. When defined, each frame
// carries one trailing odd-parity bit, and the latch check also verifies it.
//
// Rise-event handshake: r_rise holds single-cycle event pulses, one per bus
// line. At most one event may be present in a given cycle; two or more at once
// are a protocol error. DOUT_VLD is a one-CLK pulse with no back-pressure, and
// DOUT holds its value until the next valid latch.
module spi_2ph_lat_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SCLK1,
  input  logic                  SCLK2,
  input  logic                  LAT,
  input  logic                  SPI_SI,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VLD,
  output logic [CNT_WIDTH-1:0]  BIT_CNT,
  output logic                  BUSY,
  output logic                  FRM_ERR,
  output logic [1:0]            DBG_STATE
);

`ifdef SPI_RX_PARITY_CHK_EN
  localparam int SR_W       = DATA_WIDTH + 1;
  localparam int FRAME_BITS = DATA_WIDTH + 1;
  localparam int CNT_SAT    = DATA_WIDTH + 2;
`else
  localparam int SR_W       = DATA_WIDTH;
  localparam int FRAME_BITS = DATA_WIDTH;
  localparam int CNT_SAT    = DATA_WIDTH + 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PH1  = 2'd1,
    S_PH2  = 2'd2
  } state_t;

  // Line order inside the sync bundle: {LAT, SCLK2, SCLK1, SPI_SI}.
  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0]                  r_hist;
  logic [2:0]                  r_rise;   // {LAT, SCLK2, SCLK1} rise events
  logic                        r_si;     // SPI_SI, aligned with r_rise
  logic [3:0]                  w_sync;
  logic [3:0]                  w_pins;

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_master;
  logic [SR_W-1:0]             r_shift;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]       r_dout;
  logic                        r_vld;
  logic                        r_err;

  logic                        w_r1;
  logic                        w_r2;
  logic                        w_rl;
  logic                        w_multi;
  logic                        w_load;
  logic                        w_shift;
  logic                        w_latch_chk;
  logic                        w_proto_err;
  logic                        w_parity_ok;
  logic                        w_latch_ok;
  logic                        w_err_any;

  assign w_pins = {LAT, SCLK2, SCLK1, SPI_SI};
  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchronizer chain, history flop, and registered rise-event detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync <= '0;
      r_hist <= '0;
      r_rise <= '0;
      r_si   <= 1'b0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_hist <= w_sync;
      r_rise <= w_sync[3:1] & ~r_hist[3:1];
      r_si   <= w_sync[0];
    end
  end

  assign w_r1    = r_rise[0];
  assign w_r2    = r_rise[1];
  assign w_rl    = r_rise[2];
  assign w_multi = (w_r1 & w_r2) | (w_r1 & w_rl) | (w_r2 & w_rl);

`ifdef SPI_RX_PARITY_CHK_EN
  // Odd parity: payload plus parity bit must contain an odd number of ones.
  assign w_parity_ok = ^r_shift;
`else
  assign w_parity_ok = 1'b1;
`endif

  // Next-state logic and per-cycle action strobes.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_latch_chk = 1'b0;
    w_proto_err = 1'b0;
    if (w_multi) begin
      w_proto_err = 1'b1;
      w_next      = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_r1) begin
            w_load = 1'b1;
            w_next = S_PH1;
          end else if (w_r2 || w_rl) begin
            w_proto_err = 1'b1;
            w_next      = S_IDLE;
          end
        end
        S_PH1: begin
          if (w_r2) begin
            w_shift = 1'b1;
            w_next  = S_PH2;
          end else if (w_r1 || w_rl) begin
            w_proto_err = 1'b1;
            w_next      = S_IDLE;
          end
        end
        S_PH2: begin
          if (w_r1) begin
            w_load = 1'b1;
            w_next = S_PH1;
          end else if (w_rl) begin
            w_latch_chk = 1'b1;
            w_next      = S_IDLE;
          end else if (w_r2) begin
            w_proto_err = 1'b1;
            w_next      = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_latch_ok = w_latch_chk && (r_cnt == CNT_WIDTH'(FRAME_BITS)) && w_parity_ok;
  assign w_err_any  = w_proto_err | (w_latch_chk & ~w_latch_ok);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Master/slave datapath, bit counter, output register and sticky error.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_master <= 1'b0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_load)  r_master <= r_si;
      if (w_shift) r_shift  <= {r_shift[SR_W-2:0], r_master};
      if (w_err_any || w_latch_chk) begin
        r_cnt <= '0;
      end else if (w_shift && (r_cnt != CNT_WIDTH'(CNT_SAT))) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_latch_ok) r_dout <= r_shift[SR_W-1 -: DATA_WIDTH];
      r_vld <= w_latch_ok;
      // A new error takes priority over a simultaneous clear request.
      if (w_err_any)    r_err <= 1'b1;
      else if (CLR_ERR) r_err <= 1'b0;
    end
  end

  assign DOUT      = r_dout;
  assign DOUT_VLD  = r_vld;
  assign BIT_CNT   = r_cnt;
  assign FRM_ERR   = r_err;
  assign BUSY      = (r_state != S_IDLE);
  assign DBG_STATE = r_state;

endmodule
